// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID pipeline register
//
// Purpose: holds the PC, issues word requests to instruction memory over a
// req/ready handshake, captures returned words into the IF/ID register and
// presents the opcode field to the control unit. Handles stall, branch
// redirect, bubble insertion and discard of in-flight responses.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   stall          downstream hazard stall (freezes PC and IF/ID)
//   branch_taken   one-cycle redirect pulse, branch_target sampled with it
//   imem_req/addr  request to instruction memory (addr = pc in all states)
//   imem_rdata     returned word, valid with imem_ready
//   imem_ready     memory accepts request and returns data this cycle
//   if_id_instr    registered instruction
//   if_id_pc4      registered PC+4 of that instruction
//   if_id_valid    IF/ID holds a real instruction
//   opcode         if_id_instr[31:26]

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic              if_id_valid,
    output logic [5:0]        opcode
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [31:0]       skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_pc4_q, skid_pc4_d;
    logic [31:0]       if_instr_q, if_instr_d;
    logic [ADDR_W-1:0] if_pc4_q, if_pc4_d;
    logic              if_valid_q, if_valid_d;
    logic [ADDR_W-1:0] pc_plus4;

    // Modulo 2^ADDR_W: the carry out of the top bit is simply dropped.
    assign pc_plus4 = pc_q + ADDR_W'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC[ADDR_W-1:0];
            redirect_pc_q <= '0;
            skid_instr_q  <= '0;
            skid_pc4_q    <= '0;
            if_instr_q    <= '0;
            if_pc4_q      <= '0;
            if_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc4_q    <= skid_pc4_d;
            if_instr_q    <= if_instr_d;
            if_pc4_q      <= if_pc4_d;
            if_valid_q    <= if_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        skid_instr_d  = skid_instr_q;
        skid_pc4_d    = skid_pc4_q;
        if_instr_d    = if_instr_q;
        if_pc4_d      = if_pc4_q;
        if_valid_d    = if_valid_q;
        imem_req      = 1'b0;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    if_instr_d = '0;
                    if_valid_d = 1'b0;
                    if (imem_ready) begin
                        pc_d = branch_target;
                    end else begin
                        // Old request must still complete; its data is dropped in DRAIN.
                        redirect_pc_d = branch_target;
                        state_d       = DRAIN;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_plus4;
                    if (!stall) begin
                        if_instr_d = imem_rdata;
                        if_pc4_d   = pc_plus4;
                        if_valid_d = 1'b1;
                    end else begin
                        // Word already accepted by memory; park it until the stall lifts.
                        skid_instr_d = imem_rdata;
                        skid_pc4_d   = pc_plus4;
                        state_d      = HOLD;
                    end
                end else if (!stall) begin
                    if_instr_d = '0;
                    if_valid_d = 1'b0;
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    pc_d         = branch_target;
                    skid_instr_d = '0;
                    skid_pc4_d   = '0;
                    if_instr_d   = '0;
                    if_valid_d   = 1'b0;
                    state_d      = FETCH;
                end else if (!stall) begin
                    if_instr_d = skid_instr_q;
                    if_pc4_d   = skid_pc4_q;
                    if_valid_d = 1'b1;
                    state_d    = FETCH;
                end
            end

            DRAIN: begin
                imem_req   = 1'b1;
                if_instr_d = '0;
                if_valid_d = 1'b0;
                if (imem_ready) begin
                    pc_d    = branch_taken ? branch_target : redirect_pc_q;
                    state_d = FETCH;
                end else if (branch_taken) begin
                    redirect_pc_d = branch_target;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = if_instr_q;
    assign if_id_pc4   = if_pc4_q;
    assign if_id_valid = if_valid_q;
    assign opcode      = if_instr_q[31:26];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  opcode;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .opcode        (opcode)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h8C08_0004;
            32'h0000_0004: return 32'h0109_5020;
            32'h0000_0008: return 32'hAC0A_0008;
            32'h0000_000C: return 32'h1109_0003;
            32'h0000_0010: return 32'h2001_0010;
            32'h0000_0014: return 32'hDEAD_BEEF;
            32'h0000_0040: return 32'h2002_0040;
            32'h0000_0044: return 32'h2003_0044;
            32'hFFFF_FFFC: return 32'h2004_FFFC;
            default:       return {16'hCAFE, a[15:0]};
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [31:0] instr,
                          input logic [31:0] pc4, input logic valid);
        chk({tag, ".instr"}, if_id_instr, instr);
        chk({tag, ".pc4"}, if_id_pc4, pc4);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    endtask

    initial begin
        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_ready    = 1'b1;
        #3;
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk("rst.addr", imem_addr, 32'h0);
        chk_if("rst", 32'h0, 32'h0, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("boot.req", {31'd0, imem_req}, 32'd0);

        // BOOT -> FETCH
        tick();
        chk("fetch0.req", {31'd0, imem_req}, 32'd1);
        chk("fetch0.addr", imem_addr, 32'h0);
        chk("fetch0.valid", {31'd0, if_id_valid}, 32'd0);

        // Back-to-back fetch at 0 and 4
        tick();
        chk_if("w0", 32'h8C08_0004, 32'h4, 1'b1);
        chk("w0.op", {26'd0, opcode}, 32'h23);
        tick();
        chk_if("w1", 32'h0109_5020, 32'h8, 1'b1);
        chk("w1.op", {26'd0, opcode}, 32'h00);

        // Memory not ready for 3 cycles at address 8
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait.addr", imem_addr, 32'h8);
            chk("wait.req", {31'd0, imem_req}, 32'd1);
            chk_if("wait", 32'h0, 32'h8, 1'b0);
        end
        imem_ready = 1'b1;
        tick();
        chk_if("w2", 32'hAC0A_0008, 32'hC, 1'b1);
        chk("w2.op", {26'd0, opcode}, 32'h2B);

        // Stall for 2 cycles as word at 12 returns
        stall = 1'b1;
        tick();
        chk("hold1.req", {31'd0, imem_req}, 32'd0);
        chk_if("hold1", 32'hAC0A_0008, 32'hC, 1'b1);
        tick();
        chk("hold2.req", {31'd0, imem_req}, 32'd0);
        chk_if("hold2", 32'hAC0A_0008, 32'hC, 1'b1);
        stall = 1'b0;
        tick();
        chk_if("skid", 32'h1109_0003, 32'h10, 1'b1);
        chk("skid.addr", imem_addr, 32'h10);
        chk("skid.req", {31'd0, imem_req}, 32'd1);
        tick();
        chk_if("w4", 32'h2001_0010, 32'h14, 1'b1);

        // Branch while request at 0x14 is not ready -> DRAIN
        imem_ready    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        tick();
        branch_taken = 1'b0;
        chk_if("drain1", 32'h0, 32'h14, 1'b0);
        chk("drain1.addr", imem_addr, 32'h14);
        chk("drain1.req", {31'd0, imem_req}, 32'd1);
        tick();
        chk("drain2.addr", imem_addr, 32'h14);
        imem_ready = 1'b1;
        tick();
        chk("redir.addr", imem_addr, 32'h40);
        chk_if("redir", 32'h0, 32'h14, 1'b0);
        tick();
        chk_if("w40", 32'h2002_0040, 32'h44, 1'b1);

        // Branch during stall in HOLD drops the skid word
        stall = 1'b1;
        tick();
        chk("hb.hold.req", {31'd0, imem_req}, 32'd0);
        branch_taken  = 1'b1;
        branch_target = 32'h80;
        tick();
        branch_taken = 1'b0;
        stall        = 1'b0;
        chk("hb.addr", imem_addr, 32'h80);
        chk("hb.req", {31'd0, imem_req}, 32'd1);
        chk_if("hb", 32'h0, 32'h44, 1'b0);

        // Branch with ready in FETCH, then PC wrap-around
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);
        chk_if("brr", 32'h0, 32'h44, 1'b0);
        tick();
        chk_if("wrap", 32'h2004_FFFC, 32'h0, 1'b1);
        chk("wrap.next", imem_addr, 32'h0);

        // Newest redirect wins in DRAIN
        imem_ready    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        tick();
        branch_target = 32'h200;
        tick();
        branch_taken = 1'b0;
        chk("nr.addr", imem_addr, 32'h0);
        imem_ready = 1'b1;
        tick();
        chk("nr.redir", imem_addr, 32'h200);

        // Branch in same cycle as DRAIN completion uses the fresh target
        imem_ready    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h300;
        tick();
        imem_ready    = 1'b1;
        branch_target = 32'h340;
        tick();
        branch_taken = 1'b0;
        chk("same.redir", imem_addr, 32'h340);

        // Reset asserted mid-DRAIN
        imem_ready    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h500;
        tick();
        branch_taken = 1'b0;
        chk("pre.req", {31'd0, imem_req}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar.req", {31'd0, imem_req}, 32'd0);
        chk("ar.addr", imem_addr, 32'h0);
        chk_if("ar", 32'h0, 32'h0, 1'b0);
        chk("ar.op", {26'd0, opcode}, 32'h0);
        imem_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rb.req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("rb.valid", {31'd0, if_id_valid}, 32'd0);
        chk("rb.addr", imem_addr, 32'h0);
        tick();
        chk_if("rb.w0", 32'h8C08_0004, 32'h4, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
